motor_mixer: RTL and testbench



---
 rtl/motor_mixer_pkg.sv | 45 ++++
 rtl/motor_mixer_sat.sv | 49 ++++
 rtl/motor_mixer.sv | 139 +++++++++++++
 tb/tb_motor_mixer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_mixer_pkg.sv
// Shared widths, FSM encodings and mixing helpers
// for the quad-X motor mixer.
package motor_mixer_pkg;

    localparam int MOTOR_BIT_WIDTH    = 16;
    localparam int MIX_OPS_BIT_WIDTH  = 20;
    localparam int PID_RATE_BIT_WIDTH = 16;
    localparam int MIX_STATE_WIDTH    = 5;

    // One-hot mixer FSM encodings
    localparam logic [4:0] ST_WAIT     = 5'b00001;
    localparam logic [4:0] ST_LATCH    = 5'b00010;
    localparam logic [4:0] ST_SUM      = 5'b00100;
    localparam logic [4:0] ST_CLAMP    = 5'b01000;
    localparam logic [4:0] ST_COMPLETE = 5'b10000;

    typedef logic signed [MIX_OPS_BIT_WIDTH-1:0] mix_t;

    // Inputs captured in LATCH, consumed by SUM and CLAMP
    typedef struct packed {
        mix_t thr;
        mix_t roll;
        mix_t pitch;
        mix_t yaw;
        logic armed;
    } mix_latch_t;

    // Unsigned motor-range value widened to the mixing width
    function automatic mix_t zext_motor(
        input logic [MOTOR_BIT_WIDTH-1:0] v
    );
        return mix_t'({4'b0000, v});
    endfunction

    // Signed rate widened to the mixing width, then scaled down
    function automatic mix_t sext_rate(
        input logic [PID_RATE_BIT_WIDTH-1:0] v,
        input logic [3:0]                    sh
    );
        mix_t r;
        r = mix_t'({{4{v[PID_RATE_BIT_WIDTH-1]}}, v});
        return r >>> sh;
    endfunction

endpackage

// File: rtl/motor_mixer_sat.sv
// Registered clamp: 20-bit signed mix sum to
// 16-bit unsigned motor command.
module motor_sat
    import motor_mixer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic                       clear_i,
    input  logic                       force_zero_i,
    input  logic signed [MIX_OPS_BIT_WIDTH-1:0] sum_i,
    input  logic [MOTOR_BIT_WIDTH-1:0] min_i,
    input  logic [MOTOR_BIT_WIDTH-1:0] max_i,
    output logic [MOTOR_BIT_WIDTH-1:0] cmd_o
);

    logic [MOTOR_BIT_WIDTH-1:0] cmd_q;
    logic [MOTOR_BIT_WIDTH-1:0] cmd_d;

    // Clear beats load; clamp priority: zero, min, max, pass
    always_comb begin
        cmd_d = cmd_q;
        if (clear_i) begin
            cmd_d = '0;
        end else if (load_i) begin
            if (force_zero_i) begin
                cmd_d = '0;
            end else if (sum_i < zext_motor(min_i)) begin
                cmd_d = min_i;
            end else if (sum_i > zext_motor(max_i)) begin
                cmd_d = max_i;
            end else begin
                cmd_d = sum_i[MOTOR_BIT_WIDTH-1:0];
            end
        end
    end

    // Command register holds its value between loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign cmd_o = cmd_q;

endmodule

// File: rtl/motor_mixer.sv
// Quad-X mixer: throttle plus roll/pitch/yaw rates
// into four saturated motor commands.
module motor_mixer
    import motor_mixer_pkg::*;
#(
    parameter logic [15:0] MOTOR_MIN     = 16'd0,
    parameter logic [15:0] MOTOR_MAX     = 16'd1000,
    parameter logic [15:0] IDLE_THROTTLE = 16'd50,
    parameter logic [3:0]  RATE_SHIFT    = 4'd0
) (
    input  logic                          us_clk,
    input  logic                          reset,
    input  logic [MOTOR_BIT_WIDTH-1:0]    throttle,
    input  logic [PID_RATE_BIT_WIDTH-1:0] roll_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0] pitch_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0] yaw_rate,
    input  logic                          armed,
    input  logic                          start_flag,
    input  logic                          wait_flag,
    output logic [MOTOR_BIT_WIDTH-1:0]    motor_1_cmd,
    output logic [MOTOR_BIT_WIDTH-1:0]    motor_2_cmd,
    output logic [MOTOR_BIT_WIDTH-1:0]    motor_3_cmd,
    output logic [MOTOR_BIT_WIDTH-1:0]    motor_4_cmd,
    output logic                          mixer_active,
    output logic                          mixer_complete
);

    logic [MIX_STATE_WIDTH-1:0] state_q;
    logic [MIX_STATE_WIDTH-1:0] state_d;
    mix_latch_t                 lat_q;
    mix_latch_t                 lat_d;
    mix_t [3:0]                 sum_q;
    mix_t [3:0]                 sum_d;
    logic                       load;
    logic                       clear;
    logic                       force_zero;
    logic [3:0][MOTOR_BIT_WIDTH-1:0] cmd;

    // Next state; a live disarm aborts from any state
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        sum_d   = sum_q;
        load    = 1'b0;
        clear   = 1'b0;
        if (!armed) begin
            state_d = ST_WAIT;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (start_flag) begin
                        state_d = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    lat_d.thr   = zext_motor(throttle);
                    lat_d.roll  = sext_rate(roll_rate, RATE_SHIFT);
                    lat_d.pitch = sext_rate(pitch_rate, RATE_SHIFT);
                    lat_d.yaw   = sext_rate(yaw_rate, RATE_SHIFT);
                    lat_d.armed = armed;
                    state_d     = ST_SUM;
                end
                ST_SUM: begin
                    sum_d[0] = lat_q.thr + lat_q.pitch
                             + lat_q.roll - lat_q.yaw;
                    sum_d[1] = lat_q.thr + lat_q.pitch
                             - lat_q.roll + lat_q.yaw;
                    sum_d[2] = lat_q.thr - lat_q.pitch
                             - lat_q.roll - lat_q.yaw;
                    sum_d[3] = lat_q.thr - lat_q.pitch
                             + lat_q.roll + lat_q.yaw;
                    state_d  = ST_CLAMP;
                end
                ST_CLAMP: begin
                    load    = 1'b1;
                    state_d = ST_COMPLETE;
                end
                ST_COMPLETE: begin
                    if (wait_flag) begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    clear   = 1'b1;
                end
            endcase
        end
    end

    // FSM and datapath pipeline registers
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            lat_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            sum_q   <= sum_d;
        end
    end

    // Disarmed or idle throttle forces every motor off
    always_comb begin
        force_zero = !lat_q.armed
                   || (lat_q.thr < zext_motor(IDLE_THROTTLE));
    end

    for (genvar i = 0; i < 4; i++) begin : g_sat
        motor_sat u_sat (
            .clk          (us_clk),
            .rst          (reset),
            .load_i       (load),
            .clear_i      (clear),
            .force_zero_i (force_zero),
            .sum_i        (sum_q[i]),
            .min_i        (MOTOR_MIN),
            .max_i        (MOTOR_MAX),
            .cmd_o        (cmd[i])
        );
    end

    assign motor_1_cmd = cmd[0];
    assign motor_2_cmd = cmd[1];
    assign motor_3_cmd = cmd[2];
    assign motor_4_cmd = cmd[3];

    // Status flags decoded from the one-hot state
    always_comb begin
        mixer_active   = (state_q == ST_LATCH)
                       || (state_q == ST_SUM)
                       || (state_q == ST_CLAMP)
                       || (state_q == ST_COMPLETE);
        mixer_complete = (state_q == ST_COMPLETE);
    end

endmodule

// File: tb/tb_motor_mixer.sv
// Directed self-checking bench for motor_mixer.
// A second instance covers RATE_SHIFT=2.
module tb_motor_mixer;

    logic        clk;
    logic        reset;
    logic [15:0] throttle;
    logic [15:0] roll_rate;
    logic [15:0] pitch_rate;
    logic [15:0] yaw_rate;
    logic        armed;
    logic        start_flag;
    logic        wait_flag;
    logic [15:0] m1, m2, m3, m4;
    logic        active, complete;
    logic [15:0] s1, s2, s3, s4;
    logic        s_active, s_complete;

    int checks;
    int failures;

    motor_mixer dut (
        .us_clk         (clk),
        .reset          (reset),
        .throttle       (throttle),
        .roll_rate      (roll_rate),
        .pitch_rate     (pitch_rate),
        .yaw_rate       (yaw_rate),
        .armed          (armed),
        .start_flag     (start_flag),
        .wait_flag      (wait_flag),
        .motor_1_cmd    (m1),
        .motor_2_cmd    (m2),
        .motor_3_cmd    (m3),
        .motor_4_cmd    (m4),
        .mixer_active   (active),
        .mixer_complete (complete)
    );

    motor_mixer #(.RATE_SHIFT(4'd2)) dut_s (
        .us_clk         (clk),
        .reset          (reset),
        .throttle       (throttle),
        .roll_rate      (roll_rate),
        .pitch_rate     (pitch_rate),
        .yaw_rate       (yaw_rate),
        .armed          (armed),
        .start_flag     (start_flag),
        .wait_flag      (wait_flag),
        .motor_1_cmd    (s1),
        .motor_2_cmd    (s2),
        .motor_3_cmd    (s3),
        .motor_4_cmd    (s4),
        .mixer_active   (s_active),
        .mixer_complete (s_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input int t, input int r,
                              input int p, input int y);
        throttle   = 16'(t);
        roll_rate  = 16'(r);
        pitch_rate = 16'(p);
        yaw_rate   = 16'(y);
    endtask

    // Start pulse, then wait until the CLAMP edge has passed
    task automatic run_mix(input int t, input int r,
                           input int p, input int y);
        @(negedge clk);
        set_inputs(t, r, p, y);
        armed      = 1'b1;
        wait_flag  = 1'b0;
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ack();
        wait_flag = 1'b1;
        @(negedge clk);
        wait_flag = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        armed      = 1'b1;
        start_flag = 1'b0;
        wait_flag  = 1'b0;
        set_inputs(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({m1, m2, m3, m4} !== 64'd0) begin
            failures++;
            $display("FAIL reset_cmds got %0d %0d %0d %0d exp 0",
                     m1, m2, m3, m4);
        end
        checks++;
        if ({active, complete} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got a=%b c=%b exp 0 0",
                     active, complete);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_mix();
        run_mix(500, 100, 0, 0);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd600, 16'd400, 16'd400, 16'd600}) begin
            failures++;
            $display("FAIL basic_mix got %0d %0d %0d %0d exp 600 400 400 600",
                     m1, m2, m3, m4);
        end
        checks++;
        if ({active, complete} !== 2'b11) begin
            failures++;
            $display("FAIL basic_flags got a=%b c=%b exp 1 1",
                     active, complete);
        end
        ack();
        checks++;
        if ({active, complete} !== 2'b00) begin
            failures++;
            $display("FAIL ack_flags got a=%b c=%b exp 0 0",
                     active, complete);
        end
    endtask

    task automatic test_upper_sat();
        run_mix(950, 0, 200, 0);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd1000, 16'd1000, 16'd750, 16'd750}) begin
            failures++;
            $display("FAIL upper_sat got %0d %0d %0d %0d exp 1000 1000 750 750",
                     m1, m2, m3, m4);
        end
        ack();
    endtask

    task automatic test_lower_sat_yaw();
        run_mix(100, -300, 0, 0);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd0, 16'd400, 16'd400, 16'd0}) begin
            failures++;
            $display("FAIL lower_sat got %0d %0d %0d %0d exp 0 400 400 0",
                     m1, m2, m3, m4);
        end
        ack();
        run_mix(500, 0, 0, 50);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd450, 16'd550, 16'd450, 16'd550}) begin
            failures++;
            $display("FAIL yaw_mix got %0d %0d %0d %0d exp 450 550 450 550",
                     m1, m2, m3, m4);
        end
        ack();
    endtask

    task automatic test_idle_shift();
        run_mix(40, 300, -200, 77);
        checks++;
        if ({m1, m2, m3, m4} !== 64'd0) begin
            failures++;
            $display("FAIL idle_zero got %0d %0d %0d %0d exp 0",
                     m1, m2, m3, m4);
        end
        ack();
        run_mix(500, 400, 0, 0);
        checks++;
        if ({s1, s2, s3, s4} !==
            {16'd600, 16'd400, 16'd400, 16'd600}) begin
            failures++;
            $display("FAIL shift2 got %0d %0d %0d %0d exp 600 400 400 600",
                     s1, s2, s3, s4);
        end
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd900, 16'd100, 16'd100, 16'd900}) begin
            failures++;
            $display("FAIL shift0 got %0d %0d %0d %0d exp 900 100 100 900",
                     m1, m2, m3, m4);
        end
        ack();
    endtask

    task automatic test_disarm();
        @(negedge clk);
        set_inputs(800, 0, 0, 0);
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        @(negedge clk);
        armed = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1, m2, m3, m4} !== 64'd0) begin
            failures++;
            $display("FAIL disarm_cmds got %0d %0d %0d %0d exp 0",
                     m1, m2, m3, m4);
        end
        checks++;
        if ({active, complete} !== 2'b00) begin
            failures++;
            $display("FAIL disarm_flags got a=%b c=%b exp 0 0",
                     active, complete);
        end
        run_mix(600, 0, 100, 0);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd700, 16'd700, 16'd500, 16'd500}) begin
            failures++;
            $display("FAIL rearm_mix got %0d %0d %0d %0d exp 700 700 500 500",
                     m1, m2, m3, m4);
        end
        ack();
    endtask

    task automatic test_hold_complete();
        run_mix(300, 0, 0, 0);
        start_flag = 1'b1;
        set_inputs(900, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({m1, m2, m3, m4, complete} !==
                {16'd300, 16'd300, 16'd300, 16'd300, 1'b1}) begin
                failures++;
                $display("FAIL hold_c%0d got %0d %0d %0d %0d c=%b exp 300 c=1",
                         i, m1, m2, m3, m4, complete);
            end
        end
        wait_flag = 1'b1;
        @(negedge clk);
        wait_flag = 1'b0;
        checks++;
        if ({active, complete} !== 2'b00) begin
            failures++;
            $display("FAIL both_to_wait got a=%b c=%b exp 0 0",
                     active, complete);
        end
        @(negedge clk);
        start_flag = 1'b0;
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL restart_latch got a=%b exp 1", active);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({m1, complete} !== {16'd900, 1'b1}) begin
            failures++;
            $display("FAIL restart_mix got m1=%0d c=%b exp 900 1",
                     m1, complete);
        end
        ack();
    endtask

    task automatic test_reset_clamp();
        @(negedge clk);
        set_inputs(200, 0, 0, 0);
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd900, 16'd900, 16'd900, 16'd900}) begin
            failures++;
            $display("FAIL pre_clamp_hold got %0d %0d %0d %0d exp 900",
                     m1, m2, m3, m4);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({m1, m2, m3, m4, active, complete} !== 66'd0) begin
            failures++;
            $display("FAIL async_reset got %0d %0d %0d %0d a=%b c=%b exp 0",
                     m1, m2, m3, m4, active, complete);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1, m2, m3, m4, complete} !== 65'd0) begin
            failures++;
            $display("FAIL post_reset got %0d %0d %0d %0d c=%b exp 0",
                     m1, m2, m3, m4, complete);
        end
        run_mix(500, 0, 0, 50);
        checks++;
        if ({m1, m2, m3, m4} !==
            {16'd450, 16'd550, 16'd450, 16'd550}) begin
            failures++;
            $display("FAIL recover_mix got %0d %0d %0d %0d exp 450 550 450 550",
                     m1, m2, m3, m4);
        end
        ack();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_mix();
        test_upper_sat();
        test_lower_sat_yaw();
        test_idle_shift();
        test_disarm();
        test_hold_complete();
        test_reset_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
